// File: rtl/snake_pkg.sv
// snake_pkg: shared encodings for the snake game controller and drawer.
package snake_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_PLAY = 2'b01, ST_OVER = 2'b11} state_t;
  typedef enum logic [2:0] {DIR_IDLE = 3'd0, DIR_UP = 3'd1, DIR_DOWN = 3'd2, DIR_LEFT = 3'd3, DIR_RIGHT = 3'd4} dir_t;
  typedef enum logic [1:0] {COL_NONE = 2'b00, COL_WALL = 2'b01, COL_APPLE = 2'b10, COL_SELF = 2'b11} col_t;

  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a == DIR_UP && b == DIR_DOWN) || (a == DIR_DOWN && b == DIR_UP) ||
           (a == DIR_LEFT && b == DIR_RIGHT) || (a == DIR_RIGHT && b == DIR_LEFT);
  endfunction
endpackage

// File: rtl/snake_dir_filter.sv
// snake_dir_filter: button priority, reverse rejection and the pending direction register.
module snake_dir_filter
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] btn,
  input  dir_t       committed,
  input  logic       clear,
  output dir_t       pending
);
  dir_t req;

  always_comb req = btn[3] ? DIR_UP : btn[2] ? DIR_DOWN : btn[1] ? DIR_LEFT : btn[0] ? DIR_RIGHT : DIR_IDLE;

  // Reversal is judged against the committed heading so the snake can never fold onto itself.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pending <= DIR_IDLE;
    else if (clear) pending <= DIR_IDLE;
    else if (req != DIR_IDLE && !is_reverse(req, committed)) pending <= req;
endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game FSM, step timer and once-per-frame collision resolver.
// Define SNAKE_SCORE_EN to add the 8-bit apple score output.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int SIZE            = 10,
  parameter int BIT             = 10,
  parameter int H_RES           = 640,
  parameter int V_RES           = 480,
  parameter int FRAMES_PER_STEP = 8,
  parameter int GAMEOVER_FRAMES = 120
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [BIT-1:0] x_pos,
  input  logic [BIT-1:0] y_pos,
  input  logic           frame_tick,
  input  logic [3:0]     btn,
  input  logic           snake_head_active,
  input  logic           snake_body_active,
  input  logic           apple_active,
  output logic [1:0]     game_state,
  output logic [2:0]     direction,
  output logic           update,
`ifdef SNAKE_SCORE_EN
  output logic [1:0]     collision,
  output logic [7:0]     score
`else
  output logic [1:0]     collision
`endif
);
  localparam int SW = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int GW = GAMEOVER_FRAMES > 1 ? $clog2(GAMEOVER_FRAMES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(FRAMES_PER_STEP - 1);
  localparam logic [GW-1:0] GO_LAST = GW'(GAMEOVER_FRAMES - 1);
  localparam logic [BIT-1:0] X_END = BIT'(H_RES);
  localparam logic [BIT-1:0] Y_END = BIT'(V_RES);
  localparam logic [BIT-1:0] BORDER = BIT'(SIZE);
  localparam logic [BIT-1:0] X_WALL = BIT'(H_RES - SIZE);
  localparam logic [BIT-1:0] Y_WALL = BIT'(V_RES - SIZE);

  state_t state;
  dir_t dir, pending;
  col_t col, resolved;
  logic self_f, apple_f, wall_f, visible, border, fatal;
  logic [SW-1:0] step;
  logic [GW-1:0] go_cnt;

  assign game_state = state;
  assign direction  = dir;
  assign collision  = col;
  assign visible    = x_pos < X_END && y_pos < Y_END;
  assign border     = x_pos < BORDER || x_pos >= X_WALL || y_pos < BORDER || y_pos >= Y_WALL;
  assign resolved   = self_f ? COL_SELF : wall_f ? COL_WALL : apple_f ? COL_APPLE : COL_NONE;
  assign fatal      = resolved == COL_WALL || resolved == COL_SELF;

  snake_dir_filter u_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn       (btn),
    .committed (dir),
    .clear     (state == ST_OVER),
    .pending   (pending)
  );

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= ST_IDLE;
      dir     <= DIR_IDLE;
      update  <= 1'b0;
      col     <= COL_NONE;
      self_f  <= 1'b0;
      apple_f <= 1'b0;
      wall_f  <= 1'b0;
      step    <= '0;
      go_cnt  <= '0;
`ifdef SNAKE_SCORE_EN
      score   <= 8'd0;
`endif
    end else begin
      update <= 1'b0;
      if (frame_tick) begin
        col     <= resolved;
        self_f  <= 1'b0;
        apple_f <= 1'b0;
        wall_f  <= 1'b0;
      end else if (state == ST_PLAY && visible && snake_head_active) begin
        self_f  <= self_f | snake_body_active;
        apple_f <= apple_f | apple_active;
        wall_f  <= wall_f | border;
      end
      if (state == ST_IDLE) begin
        if (|btn) begin
          state <= ST_PLAY;
          step  <= '0;
`ifdef SNAKE_SCORE_EN
          score <= 8'd0;
`endif
        end
      end else if (state == ST_PLAY) begin
        if (frame_tick && fatal) begin
          state  <= ST_OVER;
          dir    <= DIR_IDLE;
          step   <= '0;
          go_cnt <= '0;
        end else if (frame_tick) begin
          step <= step == STEP_LAST ? '0 : step + SW'(1);
          if (step == STEP_LAST) begin
            dir    <= pending;
            update <= 1'b1;
          end
`ifdef SNAKE_SCORE_EN
          if (resolved == COL_APPLE && score != 8'hFF) score <= score + 8'd1;
`endif
        end
      end else begin
        dir <= DIR_IDLE;
        if (frame_tick) begin
          go_cnt <= go_cnt == GO_LAST ? '0 : go_cnt + GW'(1);
          if (go_cnt == GO_LAST) begin
            state <= ST_IDLE;
            col   <= COL_NONE;
          end
        end
      end
    end
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed plus randomized checks against a frame-level game model.
module tb_snake_game_ctrl;
  localparam int SIZE = 10, H_RES = 640, V_RES = 480, FPS = 8, GOF = 120;

  logic clk = 1'b0, reset_n = 1'b0, frame_tick, head, body, apple;
  logic [9:0] x_pos, y_pos;
  logic [3:0] btn;
  logic [1:0] game_state, collision;
  logic [2:0] direction;
  logic update;
`ifdef SNAKE_SCORE_EN
  logic [7:0] score;
`endif

  int checks = 0, passes = 0;
  int m_state, m_dir, m_pend, m_upd, m_col, m_ticks, m_go, m_score;
  bit m_self, m_wall, m_apple;

  always #5 clk = ~clk;

  snake_game_ctrl dut (
    .clk(clk), .reset_n(reset_n), .x_pos(x_pos), .y_pos(y_pos), .frame_tick(frame_tick), .btn(btn),
    .snake_head_active(head), .snake_body_active(body), .apple_active(apple),
    .game_state(game_state), .direction(direction), .update(update),
`ifdef SNAKE_SCORE_EN
    .collision(collision), .score(score)
`else
    .collision(collision)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit rev(input int a, input int b);
    return a != 0 && b != 0 && (a + b == 3 || a + b == 7);
  endfunction

  task automatic model_reset();
    m_state = 0; m_dir = 0; m_pend = 0; m_upd = 0; m_col = 0;
    m_ticks = 0; m_go = 0; m_score = 0; m_self = 0; m_wall = 0; m_apple = 0;
  endtask

  // Frame-level game rules: what the outputs must be after this clock edge.
  task automatic model_step();
    int req, res, ndir, npend, nstate, ncol, nupd;
    if (!reset_n) begin
      model_reset();
      return;
    end
    req = 0;
    for (int i = 3; i >= 0; i--) if (btn[i] && req == 0) req = 4 - i;
    res = m_self ? 3 : m_wall ? 1 : m_apple ? 2 : 0;
    nupd = 0; ncol = m_col; nstate = m_state; ndir = m_dir; npend = m_pend;
    if (frame_tick) begin
      ncol = res; m_self = 0; m_wall = 0; m_apple = 0;
    end else if (m_state == 1 && x_pos < H_RES && y_pos < V_RES && head) begin
      m_self |= body;
      m_apple |= apple;
      m_wall |= x_pos < SIZE || x_pos >= H_RES - SIZE || y_pos < SIZE || y_pos >= V_RES - SIZE;
    end
    if (m_state == 3) npend = 0;
    else if (req != 0 && !rev(req, m_dir)) npend = req;
    if (m_state == 0) begin
      if (req != 0) begin nstate = 1; m_ticks = 0; m_score = 0; end
    end else if (m_state == 1) begin
      if (frame_tick && (res == 1 || res == 3)) begin
        nstate = 3; ndir = 0; m_go = 0;
      end else if (frame_tick) begin
        m_ticks++;
        if (m_ticks % FPS == 0) begin ndir = m_pend; nupd = 1; end
        if (res == 2 && m_score < 255) m_score++;
      end
    end else begin
      ndir = 0;
      if (frame_tick) begin
        m_go++;
        if (m_go == GOF) begin nstate = 0; ncol = 0; m_go = 0; end
      end
    end
    m_state = nstate; m_dir = ndir; m_pend = npend; m_col = ncol; m_upd = nupd;
  endtask

  task automatic compare_all();
    chk("game_state", int'(game_state), m_state);
    chk("direction", int'(direction), m_dir);
    chk("update", int'(update), m_upd);
    chk("collision", int'(collision), m_col);
`ifdef SNAKE_SCORE_EN
    chk("score", int'(score), m_score);
`endif
  endtask

  task automatic clr();
    frame_tick = 0; btn = 0; head = 0; body = 0; apple = 0; x_pos = 10'd320; y_pos = 10'd240;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    clr();
  endtask

  task automatic frame(input int len);
    repeat (len - 1) begin
      x_pos = 10'($urandom_range(SIZE, H_RES - SIZE - 1));
      y_pos = 10'($urandom_range(SIZE, V_RES - SIZE - 1));
      cyc();
    end
    frame_tick = 1; x_pos = 10'd700; y_pos = 10'd500;
    cyc();
  endtask

  initial begin
    clr();
    model_reset();
    repeat (2) cyc();
    chk("reset_state", int'(game_state), 0);
    chk("reset_collision", int'(collision), 0);
    reset_n = 1;
    btn = 4'b0001; cyc();
    chk("idle_to_play", int'(game_state), 1);
    repeat (8) frame(4);
    chk("first_step_dir", int'(direction), 4);
    chk("first_step_update", int'(update), 1);
    cyc();
    chk("update_one_cycle", int'(update), 0);
    btn = 4'b0010; cyc();
    repeat (8) frame(4);
    chk("reverse_rejected", int'(direction), 4);
    btn = 4'b1000; cyc();
    repeat (8) frame(4);
    chk("turn_up", int'(direction), 1);
    head = 1; apple = 1; x_pos = 10'd100; y_pos = 10'd100; cyc();
    frame(3);
    chk("apple_hit", int'(collision), 2);
`ifdef SNAKE_SCORE_EN
    chk("score_one", int'(score), 1);
`endif
    frame(3);
    chk("apple_cleared", int'(collision), 0);
    head = 1; x_pos = 10'd3; y_pos = 10'd100; cyc();
    frame(3);
    chk("wall_hit", int'(collision), 1);
    chk("wall_over", int'(game_state), 3);
    repeat (GOF - 1) frame(3);
    chk("over_held", int'(game_state), 3);
    frame(3);
    chk("over_to_idle", int'(game_state), 0);
    chk("over_col_none", int'(collision), 0);
    btn = 4'b0100; cyc();
    repeat (7) frame(3);
    head = 1; body = 1; apple = 1; x_pos = 10'd200; y_pos = 10'd200; cyc();
    frame(3);
    chk("self_wins", int'(collision), 3);
    chk("self_over", int'(game_state), 3);
    chk("self_no_update", int'(update), 0);
    repeat (GOF) frame(3);
    btn = 4'b0001; cyc();
    repeat (7) frame(3);
    repeat (2) cyc();
    frame_tick = 1; x_pos = 10'd700; reset_n = 0;
    #1;
    model_reset();
    compare_all();
    chk("async_reset_state", int'(game_state), 0);
    cyc();
    chk("reset_cancels_update", int'(update), 0);
    reset_n = 1;
    cyc();
    repeat (6000) begin
      if ($urandom_range(0, 7) == 0) btn = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 9) == 0) begin
        frame_tick = 1; x_pos = 10'd700; y_pos = 10'd500;
      end else begin
        x_pos = 10'($urandom_range(0, 700));
        y_pos = 10'($urandom_range(0, 520));
        head = $urandom_range(0, 39) == 0;
        body = head && $urandom_range(0, 7) == 0;
        apple = head && $urandom_range(0, 3) == 0;
      end
      cyc();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
